// File: rtl/mm_pkg.sv
// Shared constants and saturation helpers for the matrix-multiplier datapath.
package mm_pkg;

    localparam int MM_IDX_W = 2;
    localparam int MM_MAX_N = 4;

    localparam logic MM_SEL_A = 1'b0;
    localparam logic MM_SEL_B = 1'b1;

    function automatic logic signed [63:0] mm_sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] mm_sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Modulo-N index counter with a sticky wrap flag; rst and clr both clear value and flag.
module mm_index_counter
    import mm_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [MM_IDX_W-1:0] value,
    output logic                finish
);

    localparam logic [MM_IDX_W-1:0] LAST = MM_IDX_W'(N - 1);

    logic [MM_IDX_W-1:0] value_r;
    logic                finish_r;

    // Count, wrap at N-1 and latch the wrap until cleared.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_r  <= {MM_IDX_W{1'b0}};
            finish_r <= 1'b0;
        end else if (en) begin
            if (value_r == LAST) begin
                value_r  <= {MM_IDX_W{1'b0}};
                finish_r <= 1'b1;
            end else begin
                value_r  <= value_r + {{(MM_IDX_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign value  = value_r;
    assign finish = finish_r;

endmodule

// File: rtl/matrix_multiplier_datapath.sv
// Datapath for R = A x B: operand/result storage, MAC register D and k/row/col counters.
// Define MM_ACC_SATURATE_EN to clamp the accumulator instead of wrapping.
module matrix_multiplier_datapath
    import mm_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                k_rst,
    input  logic                row_rst,
    input  logic                col_rst,
    input  logic                enable_count_K,
    input  logic                enable_count_ROW,
    input  logic                enable_count_COL,
    input  logic                ld_D,
    input  logic [MM_IDX_W-1:0] A_row,
    input  logic [MM_IDX_W-1:0] A_col,
    input  logic [MM_IDX_W-1:0] B_row,
    input  logic [MM_IDX_W-1:0] B_col,
    input  logic [MM_IDX_W-1:0] R_row,
    input  logic [MM_IDX_W-1:0] R_col,
    output logic [MM_IDX_W-1:0] k,
    output logic [MM_IDX_W-1:0] row,
    output logic [MM_IDX_W-1:0] col,
    output logic                finish_K,
    output logic                finish_ROW,
    output logic                finish_COL,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [MM_IDX_W-1:0] wr_row,
    input  logic [MM_IDX_W-1:0] wr_col,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [MM_IDX_W-1:0] rd_row,
    input  logic [MM_IDX_W-1:0] rd_col,
    output logic [ACC_W-1:0]    rd_data
);

    localparam int                PROD_W = 2 * DATA_W;
    localparam logic [MM_IDX_W:0] N_LIM  = (MM_IDX_W + 1)'(N);

    function automatic logic in_range(input logic [MM_IDX_W-1:0] r, input logic [MM_IDX_W-1:0] c);
        return ({1'b0, r} < N_LIM) && ({1'b0, c} < N_LIM);
    endfunction

    logic signed [DATA_W-1:0] a_mem_r [MM_MAX_N][MM_MAX_N];
    logic signed [DATA_W-1:0] b_mem_r [MM_MAX_N][MM_MAX_N];
    logic signed [ACC_W-1:0]  r_mem_r [MM_MAX_N][MM_MAX_N];
    logic signed [ACC_W-1:0]  d_r;

    logic signed [DATA_W-1:0] a_op_s;
    logic signed [DATA_W-1:0] b_op_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_next_s;
`ifdef MM_ACC_SATURATE_EN
    logic signed [ACC_W:0]    sum_s;
`endif

    mm_index_counter #(.N(N)) u_k_cnt (
        .clk(clk), .rst(rst), .clr(k_rst), .en(enable_count_K), .value(k), .finish(finish_K)
    );
    mm_index_counter #(.N(N)) u_row_cnt (
        .clk(clk), .rst(rst), .clr(row_rst), .en(enable_count_ROW), .value(row), .finish(finish_ROW)
    );
    mm_index_counter #(.N(N)) u_col_cnt (
        .clk(clk), .rst(rst), .clr(col_rst), .en(enable_count_COL), .value(col), .finish(finish_COL)
    );

    // Operand fetch, product and next accumulator value.
    always_comb begin
        a_op_s     = {DATA_W{1'b0}};
        b_op_s     = {DATA_W{1'b0}};
        acc_next_s = {ACC_W{1'b0}};
        if (in_range(A_row, A_col)) begin
            a_op_s = a_mem_r[A_row][A_col];
        end else begin
            a_op_s = {DATA_W{1'b0}};
        end
        if (in_range(B_row, B_col)) begin
            b_op_s = b_mem_r[B_row][B_col];
        end else begin
            b_op_s = {DATA_W{1'b0}};
        end
        prod_s = PROD_W'(a_op_s) * PROD_W'(b_op_s);
`ifdef MM_ACC_SATURATE_EN
        sum_s = (ACC_W + 1)'(d_r) + (ACC_W + 1)'(ACC_W'(prod_s));
        // Differing top two bits of the widened sum means the ACC_W result overflowed.
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            acc_next_s = sum_s[ACC_W] ? ACC_W'(mm_sat_min(ACC_W)) : ACC_W'(mm_sat_max(ACC_W));
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s = d_r + ACC_W'(prod_s);
`endif
    end

    // Host writes into A/B; datapath reads in the same cycle see the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MM_MAX_N; i++) begin
                for (int j = 0; j < MM_MAX_N; j++) begin
                    a_mem_r[i][j] <= {DATA_W{1'b0}};
                    b_mem_r[i][j] <= {DATA_W{1'b0}};
                end
            end
        end else if (wr_en && in_range(wr_row, wr_col)) begin
            if (wr_sel == MM_SEL_A) begin
                a_mem_r[wr_row][wr_col] <= wr_data;
            end else if (wr_sel == MM_SEL_B) begin
                b_mem_r[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Multiply-accumulate register; k_rst outranks ld_D.
    always_ff @(posedge clk) begin
        if (rst || k_rst) begin
            d_r <= {ACC_W{1'b0}};
        end else if (ld_D) begin
            d_r <= acc_next_s;
        end
    end

    // Result capture of D on each column step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MM_MAX_N; i++) begin
                for (int j = 0; j < MM_MAX_N; j++) begin
                    r_mem_r[i][j] <= {ACC_W{1'b0}};
                end
            end
        end else if (enable_count_COL && in_range(R_row, R_col)) begin
            r_mem_r[R_row][R_col] <= d_r;
        end
    end

    // Combinational result read port.
    always_comb begin
        rd_data = {ACC_W{1'b0}};
        if (in_range(rd_row, rd_col)) begin
            rd_data = r_mem_r[rd_row][rd_col];
        end else begin
            rd_data = {ACC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_matrix_multiplier_datapath.sv
// Directed self-checking bench for matrix_multiplier_datapath (N=3, DATA_W=8, ACC_W=18).
module tb_matrix_multiplier_datapath;

    logic        clk = 1'b0;
    logic        rst, k_rst, row_rst, col_rst;
    logic        enable_count_K, enable_count_ROW, enable_count_COL, ld_D;
    logic [1:0]  A_row, A_col, B_row, B_col, R_row, R_col;
    logic [1:0]  k, row, col;
    logic        finish_K, finish_ROW, finish_COL;
    logic        wr_en, wr_sel;
    logic [1:0]  wr_row, wr_col;
    logic [7:0]  wr_data;
    logic [1:0]  rd_row, rd_col;
    logic signed [17:0] rd_data;

    int checks   = 0;
    int failures = 0;

    matrix_multiplier_datapath #(.N(3), .DATA_W(8), .ACC_W(18)) dut (
        .clk(clk), .rst(rst), .k_rst(k_rst), .row_rst(row_rst), .col_rst(col_rst),
        .enable_count_K(enable_count_K), .enable_count_ROW(enable_count_ROW),
        .enable_count_COL(enable_count_COL), .ld_D(ld_D),
        .A_row(A_row), .A_col(A_col), .B_row(B_row), .B_col(B_col), .R_row(R_row), .R_col(R_col),
        .k(k), .row(row), .col(col),
        .finish_K(finish_K), .finish_ROW(finish_ROW), .finish_COL(finish_COL),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: strobes set beforehand take effect at posedge; outputs settle by negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; k_rst = 1'b0; row_rst = 1'b0; col_rst = 1'b0;
        enable_count_K = 1'b0; enable_count_ROW = 1'b0; enable_count_COL = 1'b0;
        ld_D = 1'b0; wr_en = 1'b0;
    endtask

    task automatic host_wr(input logic sel, input int r, input int c, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(data);
        tick();
    endtask

    task automatic mac(input int ar, input int ac, input int br, input int bc);
        A_row = 2'(ar); A_col = 2'(ac); B_row = 2'(br); B_col = 2'(bc); ld_D = 1'b1;
        tick();
    endtask

    task automatic store_d(input int r, input int c);
        R_row = 2'(r); R_col = 2'(c); enable_count_COL = 1'b1;
        tick();
    endtask

    function automatic logic signed [31:0] rd(input int r, input int c);
        rd_row = 2'(r); rd_col = 2'(c);
        return 32'sd0;
    endfunction

    task automatic read_check(input string tag, input int r, input int c, input int exp);
        rd_row = 2'(r); rd_col = 2'(c);
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic run_product();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                k_rst = 1'b1;
                tick();
                for (int kk = 0; kk < 3; kk++) mac(r, kk, kk, c);
                store_d(r, c);
            end
        end
    endtask

    int bvals [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

    initial begin
        rst = 1'b1; k_rst = 1'b0; row_rst = 1'b0; col_rst = 1'b0;
        enable_count_K = 1'b0; enable_count_ROW = 1'b0; enable_count_COL = 1'b0; ld_D = 1'b0;
        A_row = 2'd0; A_col = 2'd0; B_row = 2'd0; B_col = 2'd0; R_row = 2'd0; R_col = 2'd0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd0;
        rd_row = 2'd0; rd_col = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset state
        check("rst_k", k, 0); check("rst_row", row, 0); check("rst_col", col, 0);
        check("rst_finK", finish_K, 0); check("rst_finROW", finish_ROW, 0); check("rst_finCOL", finish_COL, 0);
        read_check("rst_rd", 0, 0, 0);

        // Counter wrap and sticky finish
        enable_count_K = 1'b1; tick(); check("k_1", k, 1); check("finK_1", finish_K, 0);
        enable_count_K = 1'b1; tick(); check("k_2", k, 2); check("finK_2", finish_K, 0);
        enable_count_K = 1'b1; tick(); check("k_wrap", k, 0); check("finK_wrap", finish_K, 1);
        enable_count_K = 1'b1; tick(); check("k_after", k, 1); check("finK_sticky", finish_K, 1);
        k_rst = 1'b1; tick(); check("k_clr", k, 0); check("finK_clr", finish_K, 0);
        enable_count_K = 1'b1; tick();
        k_rst = 1'b1; enable_count_K = 1'b1; tick();
        check("k_rst_wins", k, 0); check("finK_rst_wins", finish_K, 0);
        for (int i = 0; i < 3; i++) begin enable_count_ROW = 1'b1; tick(); end
        check("row_wrap", row, 0); check("finROW_wrap", finish_ROW, 1);
        row_rst = 1'b1; tick(); check("finROW_clr", finish_ROW, 0);

        // Identity x B
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                host_wr(1'b0, r, c, (r == c) ? 1 : 0);
                host_wr(1'b1, r, c, bvals[r*3+c]);
            end
        run_product();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                read_check($sformatf("ident_%0d%0d", r, c), r, c, bvals[r*3+c]);
        read_check("ident_rd21", 2, 1, 8);

        // Uniform signed product
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                host_wr(1'b0, r, c, 2);
                host_wr(1'b1, r, c, -3);
            end
        run_product();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                read_check($sformatf("unif_%0d%0d", r, c), r, c, -18);

        // Out-of-range host write ignored, operand read of index 3 yields 0
        host_wr(1'b0, 3, 0, 100);
        host_wr(1'b1, 0, 3, 100);
        k_rst = 1'b1; tick();
        mac(3, 0, 0, 0);
        mac(0, 0, 0, 3);
        store_d(0, 0);
        read_check("oob_operand", 0, 0, 0);
        read_check("oob_rd", 3, 0, 0);

        // Same-cycle host write and accumulate: old A[0][0]=2 used, then new 5
        k_rst = 1'b1; tick();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd5;
        mac(0, 0, 0, 0);
        store_d(1, 1);
        read_check("wr_old_val", 1, 1, -6);
        mac(0, 0, 0, 0);
        store_d(1, 1);
        read_check("wr_new_val", 1, 1, -21);

        // Overflow on element [0][0]
        for (int i = 0; i < 3; i++) begin
            host_wr(1'b0, 0, i, 127);
            host_wr(1'b1, i, 0, 127);
        end
        k_rst = 1'b1; tick();
        for (int i = 0; i < 3; i++) mac(0, i, i, 0);
        store_d(0, 0);
        read_check("ovf_3mac", 0, 0, 48387);
        for (int i = 0; i < 6; i++) mac(0, i % 3, i % 3, 0);
        store_d(0, 0);
`ifdef MM_ACC_SATURATE_EN
        read_check("ovf_9mac", 0, 0, 131071);
`else
        read_check("ovf_9mac", 0, 0, -116983);
`endif

        // Mid-run reset with D non-zero, R filled and counters advanced
        mac(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin enable_count_K = 1'b1; enable_count_ROW = 1'b1; tick(); end
        enable_count_COL = 1'b1; R_row = 2'd3; tick();
        rst = 1'b1; tick();
        check("mrst_k", k, 0); check("mrst_row", row, 0); check("mrst_col", col, 0);
        check("mrst_finK", finish_K, 0); check("mrst_finROW", finish_ROW, 0); check("mrst_finCOL", finish_COL, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                read_check($sformatf("mrst_R%0d%0d", r, c), r, c, 0);
        store_d(2, 2);
        read_check("mrst_D", 2, 2, 0);
        mac(0, 0, 0, 0);
        mac(1, 1, 1, 1);
        store_d(2, 2);
        read_check("mrst_AB", 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
